// File: rtl/pc_select.sv
// pc_select: fetch-stage next-PC selector for the Y86-64 pipeline.
// Picks the fetch address from the predicted PC, the fall-through of a
// mispredicted jump in Memory, or the return address of a ret in Write-back.
// It flags out-of-range fetch addresses and keeps a registered record of the
// last fetch address plus a saturating redirect count.
module pc_select #(
  parameter int unsigned IMEM_BYTES = 2048,
  parameter logic [3:0]  IJXX       = 4'h7,
  parameter logic [3:0]  IRET       = 4'h9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic [63:0] F_predPC,
  input  logic        F_stall,
  output logic [63:0] f_PC,
  output logic [1:0]  f_sel,
  output logic        f_adr_er,
  output logic [63:0] last_PC,
  output logic [15:0] redirect_cnt
);

  localparam logic [1:0]  SEL_PRED = 2'd0;
  localparam logic [1:0]  SEL_MISP = 2'd1;
  localparam logic [1:0]  SEL_RET  = 2'd2;
  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  logic        mispredict;
  logic        ret_done;
  logic [63:0] last_pc_q, last_pc_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;

  // A not-taken conditional jump in Memory was predicted taken; a ret in
  // Write-back supplies its popped return address. Unconditional jmp
  // arrives with M_cnd = 1 and therefore never counts as a mispredict.
  assign mispredict = (M_icode == IJXX) && !M_cnd;
  assign ret_done   = (W_icode == IRET);

  // Priority mux: the branch correction supersedes the older ret result.
  always_comb begin
    f_PC  = F_predPC;
    f_sel = SEL_PRED;
    if (mispredict) begin
      f_PC  = M_valA;
      f_sel = SEL_MISP;
    end else if (ret_done) begin
      f_PC  = W_valM;
      f_sel = SEL_RET;
    end
  end

  // Unsigned 64-bit bound check; IMEM_BYTES - 1 is the last valid byte.
  assign f_adr_er = (f_PC >= IMEM_LIMIT);

  // Next-state for the record: capture the fetch address and count redirects,
  // saturating at all-ones so a long run never wraps back to a small value.
  always_comb begin
    last_pc_d      = last_pc_q;
    redirect_cnt_d = redirect_cnt_q;
    if (!F_stall) begin
      last_pc_d = f_PC;
      if ((f_sel != SEL_PRED) && (redirect_cnt_q != CNT_MAX)) begin
        redirect_cnt_d = redirect_cnt_q + 16'd1;
      end
    end
  end

  // State register; reset wins over stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc_q      <= '0;
      redirect_cnt_q <= '0;
    end else begin
      last_pc_q      <= last_pc_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign last_PC      = last_pc_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_select.sv
// tb_pc_select: directed and randomized checks of pc_select against a
// behavioural model of the selection rules and the registered record.
module tb_pc_select;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [63:0] F_predPC;
  logic        F_stall;
  logic [63:0] f_PC;
  logic [1:0]  f_sel;
  logic        f_adr_er;
  logic [63:0] last_PC;
  logic [15:0] redirect_cnt;

  int total = 0;
  int bad   = 0;

  // model state
  logic [63:0] m_last;
  int          m_cnt;

  pc_select dut (
    .clk(clk), .reset(reset),
    .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .F_predPC(F_predPC), .F_stall(F_stall),
    .f_PC(f_PC), .f_sel(f_sel), .f_adr_er(f_adr_er),
    .last_PC(last_PC), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  // which source the rules pick: 0 predicted, 1 mispredict, 2 ret
  function automatic int model_sel();
    if (M_icode == 4'd7 && M_cnd == 1'b0) return 1;
    if (W_icode == 4'd9) return 2;
    return 0;
  endfunction

  function automatic logic [63:0] model_pc();
    case (model_sel())
      1:       return M_valA;
      2:       return W_valM;
      default: return F_predPC;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    logic [63:0] pc;
    pc = model_pc();
    chk({tag, ".f_PC"}, f_PC, pc);
    chk({tag, ".f_sel"}, 64'(f_sel), 64'(model_sel()));
    chk({tag, ".f_adr_er"}, 64'(f_adr_er), (pc >= 64'd2048) ? 64'd1 : 64'd0);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".last_PC"}, last_PC, m_last);
    chk({tag, ".redirect_cnt"}, 64'(redirect_cnt), 64'(m_cnt));
  endtask

  // advance one edge, updating the model from the inputs seen at that edge
  task automatic tick();
    if (reset) begin
      m_last = 64'd0;
      m_cnt  = 0;
    end else if (!F_stall) begin
      m_last = model_pc();
      if (model_sel() != 0 && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] mi, input logic mc, input logic [63:0] ma,
                        input logic [3:0] wi, input logic [63:0] wv, input logic [63:0] fp);
    M_icode = mi; M_cnd = mc; M_valA = ma; W_icode = wi; W_valM = wv; F_predPC = fp;
    #1;
  endtask

  initial begin
    m_last = '0;
    m_cnt  = 0;
    reset = 1'b1; F_stall = 1'b0;
    set_in(4'd0, 1'b0, 64'd0, 4'd0, 64'd0, 64'd0);
    tick(); tick();
    check_regs("reset");
    reset = 1'b0;

    // default path
    set_in(4'd3, 1'b0, 64'h99, 4'd6, 64'h77, 64'h14);
    check_comb("default");
    chk("default.literal", f_PC, 64'h14);
    tick();
    check_regs("default");

    // mispredict, then taken jump
    set_in(4'd7, 1'b0, 64'h2C, 4'd6, 64'h77, 64'h100);
    check_comb("misp");
    chk("misp.literal", f_PC, 64'h2C);
    tick();
    check_regs("misp");
    set_in(4'd7, 1'b1, 64'h2C, 4'd6, 64'h77, 64'h100);
    check_comb("taken");
    tick();
    check_regs("taken");

    // ret and priority
    set_in(4'd1, 1'b0, 64'h55, 4'd9, 64'h40, 64'h100);
    check_comb("ret");
    chk("ret.literal", f_PC, 64'h40);
    tick();
    check_regs("ret");
    set_in(4'd7, 1'b0, 64'h22, 4'd9, 64'h40, 64'h100);
    check_comb("prio");
    chk("prio.sel", 64'(f_sel), 64'd1);
    tick();
    check_regs("prio");

    // address error boundary
    set_in(4'd3, 1'b0, 64'h0, 4'd6, 64'h0, 64'h7FF);
    check_comb("adr7ff");
    set_in(4'd3, 1'b0, 64'h0, 4'd6, 64'h0, 64'h800);
    check_comb("adr800");
    chk("adr800.literal", 64'(f_adr_er), 64'd1);
    set_in(4'd3, 1'b0, 64'h0, 4'd6, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    check_comb("adrmax");
    set_in(4'd7, 1'b0, 64'h800, 4'd6, 64'h0, 64'h10);
    check_comb("adrmisp");
    tick();
    check_regs("adrmisp");

    // stall across three mispredict edges
    F_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(4'd7, 1'b0, 64'(64'h300 + i), 4'd6, 64'h0, 64'h10);
      check_comb("stall");
      tick();
      check_regs("stall");
    end
    // reset with stall held
    reset = 1'b1;
    tick();
    check_regs("rststall");
    chk("rststall.cnt0", 64'(redirect_cnt), 64'd0);
    reset = 1'b0; F_stall = 1'b0;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [63:0] ra, rv, rp;
      ra = {$urandom, $urandom};
      rv = {$urandom, $urandom};
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) ra = 64'($urandom_range(2040, 2056));
      if ($urandom_range(0, 1) == 0) rp = 64'($urandom_range(2040, 2056));
      set_in(($urandom_range(0, 2) == 0) ? 4'd7 : 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), ra,
             ($urandom_range(0, 2) == 0) ? 4'd9 : 4'($urandom_range(0, 15)),
             rv, rp);
      F_stall = ($urandom_range(0, 4) == 0);
      reset   = ($urandom_range(0, 29) == 0);
      #1;
      check_comb("rand");
      tick();
      check_regs("rand");
    end
    reset = 1'b0; F_stall = 1'b0;

    // saturation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_in(4'd7, 1'b0, 64'h2C, 4'd0, 64'h0, 64'h10);
    for (int i = 0; i < 65534; i++) tick();
    check_regs("sat_fffe");
    tick();
    check_regs("sat_ffff");
    chk("sat.literal", 64'(redirect_cnt), 64'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    check_regs("sat_hold");
    chk("sat_hold.literal", 64'(redirect_cnt), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
